uart_rx_framer: RTL and testbench
=================================

# uart_rx_framer

Downstream consumer of the UART receive path. It pulls bytes from the receiver's `rx_rdy`/`rx_data`/`rx_ack` handshake and parses them into framed packets: SOF, LEN, payload, checksum. Payload is held in an internal buffer and released on a valid/ready stream only after the checksum passes. Malformed frames are dropped and reported.

## Interface
Parameters:
- `SOF`, 8'h55, start-of-frame byte.
- `MAX_LEN`, 16, maximum payload length in bytes (1..255); sets the buffer depth.
- `TIMEOUT_CYCLES`, 50000, inter-byte timeout in clk cycles; used only with `UART_FRAME_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, shared with the UART.
- `rst` in 1: reset, synchronous, active-high.
- `rx_rdy` in 1: receiver holds a byte.
- `rx_data` in 8: received byte.
- `rx_ack` out 1: byte consumed; one-cycle pulse.
- `out_valid` out 1: payload byte available.
- `out_data` out 8: payload byte.
- `out_last` out 1: final payload byte of the frame.
- `out_ready` in 1: sink accepts the byte.
- `frame_ok` out 1: one-cycle pulse, good frame.
- `frame_err` out 1: one-cycle pulse, frame dropped.
- `err_code` out 2: 1 = LEN > MAX_LEN, 2 = checksum, 3 = timeout. Valid while `frame_err` = 1; holds its last value otherwise.

## Operation
- States: IDLE, LEN, PAYLOAD, CSUM, DRAIN.
- Byte acceptance: `rx_ack = rx_rdy && state ∈ {IDLE, LEN, PAYLOAD, CSUM}`. The byte is captured on that edge. The receiver drops `rx_rdy` the cycle after `rx_ack`.
- IDLE:
  - A byte equal to `SOF` goes to LEN.
  - Any other byte is acked and discarded silently.
- LEN:
  - Store the length and seed `sum = LEN`.
  - LEN > MAX_LEN: `frame_err`, code 1, go to IDLE.
  - LEN = 0: go to CSUM.
  - Otherwise go to PAYLOAD.
- PAYLOAD: write the byte to the buffer at `wr_ptr`, `sum += byte` (mod 256), `cnt++`. Go to CSUM when `cnt == LEN`.
- CSUM: the frame is good when `(sum + byte) mod 256 == 0`.
  - Good and LEN > 0: `frame_ok`, go to DRAIN.
  - Good and LEN = 0: `frame_ok`, go to IDLE.
  - Bad: `frame_err`, code 2, go to IDLE, buffer discarded.
- DRAIN:
  - `out_valid` = 1 and `out_data = buf[rd_ptr]`.
  - `rd_ptr` advances on `out_valid && out_ready`.
  - `out_last` = 1 when `rd_ptr == LEN-1`.
  - The transfer with `out_last` returns to IDLE.
  - `rx_ack` is held low (backpressure); an upstream overrun is the receiver's concern.
- Leaving any state for IDLE clears `wr_ptr`, `rd_ptr`, `cnt` and `sum`.

## Timing
- Reset values: `rx_ack`, `out_valid`, `out_data`, `out_last`, `frame_ok`, `frame_err` all 0; `err_code` 0; state IDLE.
- `rst` asserted mid-frame or mid-drain aborts on the next edge. The aborted frame produces no `frame_ok`/`frame_err`.
- `rx_ack` is combinational from `rx_rdy` and the registered state: zero-cycle ack.
- `frame_ok`/`frame_err` are registered, asserted the cycle after the CSUM (or LEN) byte edge.
- First `out_valid` is in the same cycle as `frame_ok`.
- The drain sustains one byte per cycle while `out_ready` = 1.
- `out_data`/`out_last` are stable while `out_valid && !out_ready`.
- Latency from CSUM-byte ack to first `out_valid`: 1 cycle.

## Configuration
- `UART_FRAME_TIMEOUT_EN` defined:
  - A 16-bit counter runs in LEN/PAYLOAD/CSUM and clears on every accepted byte and on entering LEN.
  - When it reaches `TIMEOUT_CYCLES`: `frame_err`, code 3, go to IDLE.
  - The counter is idle in IDLE and DRAIN.
- Undefined: no counter exists, code 3 is never produced, and a partial frame waits indefinitely.

## Structure
- Package `uart_frame_pkg`:
  - state enum;
  - `ERR_LEN`/`ERR_CSUM`/`ERR_TIMEOUT` 2-bit constants;
  - default SOF constant.
- Sub-module `uart_frame_buf`: MAX_LEN×8 register array with write port (`we`, `waddr`, `wdata`) and asynchronous read (`raddr`, `rdata`). Pointer widths are `$clog2(MAX_LEN)`. The framer owns all pointers and counters.

## Test plan
- Good frame 55 03 11 22 33 97, `out_ready` = 1:
  - `frame_ok` pulses once;
  - out stream is 11, 22, 33 on consecutive cycles, `out_last` on 33;
  - `frame_err` never asserts.
- Bad checksum 55 03 11 22 33 96: `frame_err`, code 2, no `out_valid`; a following good frame parses normally.
- Preamble and edge lengths:
  - AA 00 55 00 00: AA and 00 acked and discarded, `frame_ok`, no output.
  - 55 11 (LEN 17 > 16): `frame_err` code 1 immediately after the LEN byte.
- Backpressure on the good frame: `out_ready` toggles 0,1,0,0,1,1.
  - Each byte transfers exactly once, data is held while stalled.
  - `rx_ack` stays 0 during DRAIN even with `rx_rdy` = 1.
- Reset mid-payload after 55 03 11: `rst` for 1 cycle, all outputs 0, state IDLE; the subsequent good frame succeeds.
- With `UART_FRAME_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 100: send 55 03 11, then stall for 100 cycles.
  - `frame_err` code 3 after the 100th idle cycle.
  - Without the macro, the same stimulus gives no error.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART receive framer.
// Holds the framer state encoding, error codes and the default start-of-frame byte.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_e;

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'h55;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer for the framer: one synchronous write port and an
// asynchronous read port. Pointers are owned by the framer.
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int PW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [PW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_framer.sv
// Parses UART bytes into SOF/LEN/payload/checksum frames and releases the payload
// on a valid/ready stream once the checksum passes. Define UART_FRAME_TIMEOUT_EN
// to enable the inter-byte timeout that drops stalled frames.
module uart_rx_framer
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SOF            = SOF_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_ack,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int         PW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic [7:0]    csum;
  logic [7:0]    cnt_inc;
  logic          go_idle;

  uart_frame_buf #(
    .MAX_LEN(MAX_LEN),
    .PW     (PW)
  ) u_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(wr_ptr_q),
    .wdata(rx_data),
    .raddr(rd_ptr_q),
    .rdata(buf_rdata)
  );

  // Draining applies backpressure upstream; every other state takes bytes immediately.
  assign rx_ack    = rx_rdy && (state_q != ST_DRAIN);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = out_valid ? buf_rdata : 8'h00;
  assign out_last  = out_valid && (8'(rd_ptr_q) == (len_q - 8'd1));
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

  assign csum    = sum_q + rx_data;
  assign cnt_inc = cnt_q + 8'd1;

`ifdef UART_FRAME_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        frame_active;
  logic        tmo_hit;

  always_comb begin
    frame_active = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    tmo_hit      = frame_active && !rx_ack && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
    tmo_d        = (frame_active && !rx_ack) ? tmo_q + 16'd1 : 16'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= 16'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;
    go_idle     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_ack && (rx_data == SOF)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_ack) begin
          len_d = rx_data;
          sum_d = rx_data;
          if (rx_data > MAX_LEN_B) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            go_idle     = 1'b1;
          end else if (rx_data == 8'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_ack) begin
          buf_we   = 1'b1;
          sum_d    = csum;
          cnt_d    = cnt_inc;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (cnt_inc == len_q) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (rx_ack) begin
          if (csum == 8'd0) begin
            frame_ok_d = 1'b1;
            if (len_q != 8'd0) begin
              state_d = ST_DRAIN;
            end else begin
              go_idle = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
            go_idle     = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            go_idle = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase

`ifdef UART_FRAME_TIMEOUT_EN
    if (tmo_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      go_idle     = 1'b1;
    end
`endif

    // Any return to IDLE starts the next frame from a clean slate.
    if (go_idle) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = 8'd0;
      sum_d    = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= 8'd0;
      cnt_q       <= 8'd0;
      sum_q       <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: a frame-level parser model predicts
// frame events and payload beats, a per-cycle monitor compares them against the DUT.
module tb_uart_rx_framer;
  import uart_frame_pkg::*;

  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SOF_B   = 8'h55;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ack;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_rx_framer #(
    .SOF           (SOF_B),
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_rdy   (rx_rdy),
    .rx_data  (rx_data),
    .rx_ack   (rx_ack),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code)
  );

  typedef struct packed {
    logic       isErr;
    logic [1:0] code;
    logic       hasData;
  } event_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  event_t     evQ[$];
  beat_t      dataQ[$];
  logic [7:0] outLog[$];
  int         xferCycle[$];

  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;
  int   okCount     = 0;
  int   errCount    = 0;
  bit   checkEn     = 1'b0;
  bit   readyPatternMode = 1'b0;
  logic [5:0] readyPattern = 6'b110010;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Frame-level reference: scan the byte stream the way the protocol defines frames.
  function automatic void modelStream(input logic [7:0] s[$]);
    int         i;
    int         len;
    logic [7:0] total;
    event_t     e;
    beat_t      b;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != SOF_B) begin
        i++;
        continue;
      end
      if (i + 1 >= s.size()) break;
      len = int'(s[i+1]);
      if (len > MAX_LEN) begin
        e.isErr = 1'b1; e.code = ERR_LEN; e.hasData = 1'b0;
        evQ.push_back(e);
        i += 2;
        continue;
      end
      if (i + 2 + len >= s.size()) break;
      total = 8'd0;
      for (int k = 1; k <= len + 2; k++) total = total + s[i+k];
      if (total == 8'd0) begin
        e.isErr = 1'b0; e.code = 2'd0; e.hasData = (len > 0);
        evQ.push_back(e);
        for (int k = 0; k < len; k++) begin
          b.data = s[i+2+k];
          b.last = (k == len - 1);
          dataQ.push_back(b);
        end
      end else begin
        e.isErr = 1'b1; e.code = ERR_CSUM; e.hasData = 1'b0;
        evQ.push_back(e);
      end
      i += len + 3;
    end
  endfunction

  task automatic sendByte(input logic [7:0] b);
    bit acked;
    acked = 1'b0;
    @(posedge clk); #2;
    rx_rdy  = 1'b1;
    rx_data = b;
    for (int i = 0; i < 300 && !acked; i++) begin
      @(negedge clk);
      if (rx_ack) acked = 1'b1;
    end
    checkOutput("ackWithinBound", acked, 1);
    if (acked) begin
      @(posedge clk); #2;
    end
    rx_rdy = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] s[$]);
    modelStream(s);
    foreach (s[i]) sendByte(s[i]);
  endtask

  task automatic waitDone(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (dataQ.size() == 0 && evQ.size() == 0 && !out_valid) done = 1'b1;
    end
    checkOutput(name, done, 1);
  endtask

  task automatic pulseReset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // out_ready driver: always ready, or the 0,1,0,0,1,1 pattern across each drain.
  initial begin : readyDriver
    int pIdx;
    pIdx = 0;
    forever begin
      @(posedge clk); #2;
      if (!readyPatternMode) begin
        out_ready = 1'b1;
      end else if (out_valid) begin
        out_ready = readyPattern[pIdx % 6];
        pIdx++;
      end else begin
        pIdx = 0;
        out_ready = readyPattern[0];
      end
    end
  end

  // Per-cycle monitor against the model queues.
  initial begin : compareProc
    bit         stallPrev;
    logic [7:0] stallData;
    logic       stallLast;
    beat_t      b;
    event_t     e;
    stallPrev = 1'b0;
    stallData = 8'h00;
    stallLast = 1'b0;
    forever begin
      @(negedge clk);
      if (checkEn && !rst) begin
        if (stallPrev) begin
          checkOutput("stallValid", out_valid, 1);
          checkOutput("stallData", out_data, stallData);
          checkOutput("stallLast", out_last, stallLast);
        end
        if (out_valid) checkOutput("ackInDrain", rx_ack, 0);
        if (out_valid && out_ready) begin
          outLog.push_back(out_data);
          xferCycle.push_back(cycle);
          checkOutput("beatExpected", dataQ.size() > 0, 1);
          if (dataQ.size() > 0) begin
            b = dataQ.pop_front();
            checkOutput("outData", out_data, b.data);
            checkOutput("outLast", out_last, b.last);
          end
        end
        stallPrev = out_valid && !out_ready;
        stallData = out_data;
        stallLast = out_last;
        if (frame_ok) begin
          okCount++;
          checkOutput("okExpected", evQ.size() > 0, 1);
          if (evQ.size() > 0) begin
            e = evQ.pop_front();
            checkOutput("okKind", e.isErr, 0);
            checkOutput("okFirstValid", out_valid, e.hasData);
          end
        end
        if (frame_err) begin
          errCount++;
          checkOutput("errExpected", evQ.size() > 0, 1);
          if (evQ.size() > 0) begin
            e = evQ.pop_front();
            checkOutput("errKind", e.isErr, 1);
            checkOutput("errCode", err_code, e.code);
          end
        end
      end else begin
        stallPrev = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [7:0] q[$];
    logic [7:0] good[$];
    int         okBase;
    int         errBase;

    good = {8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstRxAck", rx_ack, 0);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstOutData", out_data, 8'h00);
    checkOutput("rstOutLast", out_last, 0);
    checkOutput("rstFrameOk", frame_ok, 0);
    checkOutput("rstFrameErr", frame_err, 0);
    checkOutput("rstErrCode", err_code, 2'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    checkEn = 1'b1;

    $display("[TB] good frame, out_ready high");
    okBase = okCount; errBase = errCount;
    outLog.delete(); xferCycle.delete();
    applyStimulus(good);
    @(negedge clk);
    checkOutput("t1FrameOk", frame_ok, 1);
    checkOutput("t1FirstValid", out_valid, 1);
    checkOutput("t1FirstData", out_data, 8'h11);
    waitDone("t1Drained");
    checkOutput("t1OkCount", okCount - okBase, 1);
    checkOutput("t1ErrCount", errCount - errBase, 0);
    checkOutput("t1Beats", outLog.size(), 3);
    if (outLog.size() == 3) begin
      checkOutput("t1Byte0", outLog[0], 8'h11);
      checkOutput("t1Byte2", outLog[2], 8'h33);
      checkOutput("t1Consecutive", xferCycle[2] - xferCycle[0], 2);
    end

    $display("[TB] bad checksum followed by good frame");
    okBase = okCount; outLog.delete();
    q = {8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h96};
    applyStimulus(q);
    @(negedge clk);
    checkOutput("t2FrameErr", frame_err, 1);
    checkOutput("t2ErrCode", err_code, 2'd2);
    checkOutput("t2NoValid", out_valid, 0);
    applyStimulus(good);
    waitDone("t2Drained");
    checkOutput("t2OkCount", okCount - okBase, 1);
    checkOutput("t2CodeHeld", err_code, 2'd2);
    checkOutput("t2Beats", outLog.size(), 3);

    $display("[TB] preamble bytes and zero-length frame");
    okBase = okCount; outLog.delete();
    q = {8'hAA, 8'h00, 8'h55, 8'h00, 8'h00};
    applyStimulus(q);
    waitDone("t3Done");
    checkOutput("t3OkCount", okCount - okBase, 1);
    checkOutput("t3NoBeats", outLog.size(), 0);

    $display("[TB] oversize length");
    errBase = errCount;
    q = {8'h55, 8'h11};
    applyStimulus(q);
    @(negedge clk);
    checkOutput("t4FrameErr", frame_err, 1);
    checkOutput("t4ErrCode", err_code, 2'd1);
    waitDone("t4Done");
    checkOutput("t4ErrCount", errCount - errBase, 1);

    $display("[TB] backpressure with upstream byte waiting");
    readyPatternMode = 1'b1;
    outLog.delete();
    applyStimulus(good);
    q = {8'h55, 8'h01, 8'hAB, 8'h54};
    applyStimulus(q);
    waitDone("t5Drained");
    readyPatternMode = 1'b0;
    checkOutput("t5Beats", outLog.size(), 4);
    if (outLog.size() == 4) begin
      checkOutput("t5Byte1", outLog[1], 8'h22);
      checkOutput("t5Byte3", outLog[3], 8'hAB);
    end

    $display("[TB] maximum length frame");
    outLog.delete();
    q = {8'h55, 8'h10};
    for (int k = 1; k <= 16; k++) q.push_back(8'(k));
    q.push_back(8'h68);
    applyStimulus(q);
    waitDone("t6Drained");
    checkOutput("t6Beats", outLog.size(), 16);
    if (outLog.size() == 16) checkOutput("t6LastByte", outLog[15], 8'h10);

    $display("[TB] reset mid-payload");
    okBase = okCount; errBase = errCount; outLog.delete();
    q = {8'h55, 8'h03, 8'h11};
    applyStimulus(q);
    pulseReset();
    @(negedge clk);
    checkOutput("t7OutValid", out_valid, 0);
    checkOutput("t7OutData", out_data, 8'h00);
    checkOutput("t7FrameOk", frame_ok, 0);
    checkOutput("t7FrameErr", frame_err, 0);
    checkOutput("t7ErrCode", err_code, 2'd0);
    applyStimulus(good);
    waitDone("t7Drained");
    checkOutput("t7OkCount", okCount - okBase, 1);
    checkOutput("t7ErrCount", errCount - errBase, 0);
    checkOutput("t7Beats", outLog.size(), 3);

    $display("[TB] stalled partial frame");
    q = {8'h55, 8'h03, 8'h11};
    applyStimulus(q);
`ifdef UART_FRAME_TIMEOUT_EN
    begin
      event_t te;
      te.isErr = 1'b1; te.code = ERR_TIMEOUT; te.hasData = 1'b0;
      evQ.push_back(te);
    end
`endif
    repeat (100) @(negedge clk);
    checkOutput("t8NoErrAt100", frame_err, 0);
    @(negedge clk);
`ifdef UART_FRAME_TIMEOUT_EN
    checkOutput("t8TimeoutErr", frame_err, 1);
    checkOutput("t8TimeoutCode", err_code, 2'd3);
`else
    checkOutput("t8NoTimeout", frame_err, 0);
`endif
    repeat (10) @(negedge clk);
    checkOutput("t8QueuesEmpty", evQ.size() + dataQ.size(), 0);
    pulseReset();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
